jk_reg_counter: RTL

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register with per-bit JK control, plus up-count, down-count and parallel-load modes.
- Provides complementary outputs, a terminal-count flag and a sticky overflow flag.
- Used as a general register/counter primitive in the lab datapath wherever multi-bit JK storage or event counting is needed.

---
 rtl/jk_reg_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/jk_reg_counter.sv
// WIDTH-bit register/counter with per-bit JK control, up/down counting and parallel load.
// Provides complementary outputs, a combinational terminal-count flag and a sticky overflow flag.
module jk_reg_counter #(
    parameter int               WIDTH     = 8,
    parameter bit               NEG_EDGE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               WRAP      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    localparam logic [1:0]       MODE_JK   = 2'b00;
    localparam logic [1:0]       MODE_UP   = 2'b01;
    localparam logic [1:0]       MODE_DOWN = 2'b10;
    localparam logic [1:0]       MODE_LOAD = 2'b11;
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q, qb_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] jk_next;
    logic             up_limit, down_limit;

    // Each bit follows the JK characteristic: hold, clear, set or toggle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bit
            always_comb begin
                jk_next[gi] = q_q[gi];
                case ({j[gi], k[gi]})
                    2'b01:   jk_next[gi] = 1'b0;
                    2'b10:   jk_next[gi] = 1'b1;
                    2'b11:   jk_next[gi] = ~q_q[gi];
                    default: jk_next[gi] = q_q[gi];
                endcase
            end
        end
    endgenerate

    always_comb begin
        up_limit   = en && (mode == MODE_UP)   && (q_q == ALL_ONES);
        down_limit = en && (mode == MODE_DOWN) && (q_q == ALL_ZERO);
    end

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_JK:   q_d = jk_next;
                MODE_UP:   q_d = (up_limit && !WRAP) ? ALL_ONES : q_q + ONE;
                MODE_DOWN: q_d = (down_limit && !WRAP) ? ALL_ZERO : q_q - ONE;
                MODE_LOAD: q_d = d;
                default:   q_d = q_q;
            endcase
        end
        qb_d = ~q_d;
        // A limit event outranks a simultaneous clear request.
        if (up_limit || down_limit) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg_edge
            always_ff @(negedge clk or posedge reset) begin
                if (reset) begin
                    q_q   <= RESET_VAL;
                    qb_q  <= ~RESET_VAL;
                    ovf_q <= 1'b0;
                end else begin
                    q_q   <= q_d;
                    qb_q  <= qb_d;
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_pos_edge
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_q   <= RESET_VAL;
                    qb_q  <= ~RESET_VAL;
                    ovf_q <= 1'b0;
                end else begin
                    q_q   <= q_d;
                    qb_q  <= qb_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    endgenerate

    assign q   = q_q;
    assign qb  = qb_q;
    assign ovf = ovf_q;
    assign tc  = up_limit || down_limit;

endmodule
